// File: rtl/score_bcd_ctrl.sv
// score_bcd_ctrl: once-per-frame double-dabble conversion of a clamped binary score to four BCD digits
module score_bcd_ctrl #(
  parameter int SCORE_W   = 32,
  parameter int SAT_MAX   = 9999,
  parameter int CONV_BITS = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic [SCORE_W-1:0] score,
  input  logic               force_update,
  output logic               busy,
  output logic               digits_valid,
  output logic [3:0]         dig_unit,
  output logic [3:0]         dig_ten,
  output logic [3:0]         dig_hund,
  output logic [3:0]         dig_thou
);
  localparam int CW = $clog2(CONV_BITS);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [CONV_BITS-1:0] clamped, shiftReg, convReg, lastConv, nextShift;
  logic [15:0] scratch, adj, nextScratch;
  logic [CW-1:0] bitCnt;
  logic pending, forceFlag;
  assign clamped = (score > SCORE_W'(SAT_MAX)) ? CONV_BITS'(SAT_MAX) : score[CONV_BITS-1:0];
  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign adj[4*i+:4] = (scratch[4*i+:4] >= 4'd5) ? scratch[4*i+:4] + 4'd3 : scratch[4*i+:4];
  end
  assign {nextScratch, nextShift} = {adj, shiftReg} << 1;
  assign busy = state != IDLE;
  assign digits_valid = state == DONE;
  // Conversion sequencer: request capture, clamp/skip decision, shift-add-3 loop, atomic digit update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      shiftReg <= '0;
      convReg <= '0;
      lastConv <= '0;
      scratch <= '0;
      bitCnt <= '0;
      pending <= 1'b0;
      forceFlag <= 1'b0;
      {dig_thou, dig_hund, dig_ten, dig_unit} <= '0;
    end else begin
      pending <= (frame_tick && state != IDLE) ? 1'b1 : (state == IDLE) ? 1'b0 : pending;
      forceFlag <= force_update ? 1'b1 : (state == DONE) ? 1'b0 : forceFlag;
      case (state)
        IDLE: state <= (frame_tick || pending) ? LOAD : IDLE;
        LOAD: begin
          shiftReg <= clamped;
          convReg <= clamped;
          scratch <= '0;
          bitCnt <= CW'(CONV_BITS - 1);
          state <= (clamped == lastConv && !forceFlag) ? IDLE : SHIFT;
        end
        SHIFT: begin
          scratch <= nextScratch;
          shiftReg <= nextShift;
          bitCnt <= bitCnt - 1'b1;
          if (bitCnt == '0) begin
            state <= DONE;
            {dig_thou, dig_hund, dig_ten, dig_unit} <= nextScratch;
          end
        end
        default: begin
          lastConv <= convReg;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
